reservation_free_list: RTL and testbench
========================================

# reservation_free_list

Parametrised free-list allocator for reservation/block IDs. It is the successor to the fixed-size reservation counter. After reset it self-initialises with every ID `0..BLOCK_COUNT-1` and presents the oldest free ID first-word-fall-through on an allocate port. It accepts returned IDs on a free port and reports occupancy and protocol errors. It sits between the request scheduler, which allocates, and the completion path, which frees.

## Interface
- `BLOCK_COUNT`, 64: number of IDs managed; any value ≥ 2, not required to be a power of two.
- `ID_W`, `$clog2(BLOCK_COUNT)`: ID width; derived, do not override.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `alloc_req` in 1: consumer takes `alloc_id` this cycle.
- `alloc_valid` out 1: `rdy && !empty`; `alloc_id` is meaningful.
- `alloc_id` out `ID_W`: head of the free list (FWFT).
- `free_valid` in 1: return `free_id` to the list this cycle.
- `free_id` in `ID_W`: ID being returned.
- `count` out `ID_W+1`: number of free IDs held.
- `full` out 1: `count == BLOCK_COUNT`.
- `empty` out 1: `count == 0`.
- `rdy` out 1: initialisation complete.
- `err_underflow` out 1: one-cycle pulse; `alloc_req` while `!alloc_valid`.
- `err_overflow` out 1: one-cycle pulse; free rejected because the list is full.
- `err_double_free` out 1: one-cycle pulse; free of an ID not currently allocated. Only active with the macro in Configuration.

## Operation
- Storage: `BLOCK_COUNT`-entry circular array with head/tail pointers of `ID_W` bits. Pointers wrap at `BLOCK_COUNT-1 -> 0`, not at `2^ID_W`.
- FSM, two states:
  - INIT (entered on reset): writes `entry[i] = i` for `i = 0..BLOCK_COUNT-1`, one per cycle. `count` increments each write. `alloc_req` and `free_valid` are ignored with no error pulses.
  - After the last write the FSM moves to READY: `rdy = 1`, `head = 0`, `tail = 0` (wrapped), `count = BLOCK_COUNT`, `full = 1`.
- Allocate is accepted when `alloc_req && alloc_valid`: `head` advances and `count` decrements.
- Free is accepted when `free_valid && rdy` and either:
  - `!full`, or
  - `full` and an allocate is accepted in the same cycle.
  - On acceptance, `entry[tail] = free_id`, `tail` advances and `count` increments.
- Simultaneous accepted allocate and free: both take effect and `count` is unchanged.
  - When empty, the allocate is rejected (underflow) and the free is accepted. There is no bypass of `free_id` to `alloc_id`.
- Rejected operations leave all state unchanged.
- `count` arithmetic is `ID_W+1` bits and never exceeds `BLOCK_COUNT`.

## Timing
- Reset values:
  - `rdy = 0`, `count = 0`, `empty = 1`, `full = 0`, `alloc_valid = 0`, `alloc_id = 0`.
  - All `err_*` outputs are 0.
  - FSM is in INIT; pointers are 0.
- Initialisation: `rdy` rises exactly `BLOCK_COUNT` cycles after the first rising edge with `rst` low.
- `alloc_id` is combinational from `entry[head]`. It updates on the edge following an accepted allocate.
- A freed ID becomes visible at the next edge. It reaches `alloc_id` only when it reaches the head.
- `count`, `full` and `empty` are registered and update one edge after the accepted operation.
- `err_*` outputs are registered and pulse high for the one cycle after the offending request.
- Asserting `rst` mid-operation aborts immediately: all state returns to reset values and INIT restarts. Outstanding allocated IDs are considered reclaimed.

## Configuration
- Macro: `RESERVATION_FREE_LIST_DOUBLE_FREE_CHECK_EN`.
- Defined:
  - The block keeps a `BLOCK_COUNT`-bit allocated bitmap, cleared in INIT and set on allocate.
  - A free of an ID whose bit is clear, or of an ID `>= BLOCK_COUNT`, is rejected and pulses `err_double_free`.
  - An accepted free clears the bit.
  - An allocate and a free of the same ID in one cycle counts as a double free, because the bit is still clear at the check.
- Undefined: no bitmap; `err_double_free` is tied to 0. Frees are checked only against `full`.

## Test plan
- Reset with `BLOCK_COUNT=8` -> `rdy` low for 8 cycles, then `rdy=1`, `count=8`, `full=1`, `alloc_id=0`.
- Allocate 8 back-to-back -> `alloc_id` sequence 0..7, then `empty=1`, `alloc_valid=0`. A 9th `alloc_req` -> `err_underflow` pulse, `count` stays 0.
- Free 5, then free 3 with an allocate in the same cycle -> first allocate returns 5, `count` stays 1 on the simultaneous cycle, next `alloc_id=3`.
- `BLOCK_COUNT=6` (non-power-of-two): 20 interleaved allocate/free cycles -> pointers wrap 5→0, IDs are returned in FIFO order, `count` is never above 6.
- Macro on: free of ID 2 while full -> `err_double_free`, `count=8`. Macro off: same stimulus -> `err_overflow`, `count=8`.
- `rst` asserted mid-stream at `count=3` -> all outputs return to reset values and the full INIT sequence replays.

Source files
------------

// File: rtl/reservation_free_list.sv
// reservation_free_list
//
// Free-list allocator for reservation/block IDs. After reset the list fills
// itself with IDs 0..BLOCK_COUNT-1, one per cycle. It then hands out the
// oldest free ID first-word-fall-through on the allocate port and takes
// returned IDs on the free port.
//
// Optional feature: define RESERVATION_FREE_LIST_DOUBLE_FREE_CHECK_EN to keep
// an allocated-ID bitmap. Frees of IDs that are not currently allocated are
// then rejected and flagged on err_double_free. Without the macro,
// err_double_free is tied low.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   alloc_req         consumer takes alloc_id this cycle
//   alloc_valid       rdy && !empty; alloc_id is meaningful
//   alloc_id          head of the free list (combinational from storage)
//   free_valid        return free_id to the list this cycle
//   free_id           ID being returned
//   count             number of free IDs held (registered)
//   full, empty       count == BLOCK_COUNT / count == 0 (registered)
//   rdy               initialisation complete
//   err_underflow     1-cycle pulse: alloc_req while !alloc_valid
//   err_overflow      1-cycle pulse: free rejected because the list is full
//   err_double_free   1-cycle pulse: free of an ID not currently allocated
module reservation_free_list #(
    parameter int unsigned BLOCK_COUNT = 64,
    parameter int unsigned ID_W        = $clog2(BLOCK_COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    output logic            alloc_valid,
    output logic [ID_W-1:0] alloc_id,
    input  logic            free_valid,
    input  logic [ID_W-1:0] free_id,
    output logic [ID_W:0]   count,
    output logic            full,
    output logic            empty,
    output logic            rdy,
    output logic            err_underflow,
    output logic            err_overflow,
    output logic            err_double_free
);

    localparam logic [ID_W:0]   COUNT_MAX  = (ID_W+1)'(BLOCK_COUNT);
    localparam logic [ID_W:0]   COUNT_LAST = (ID_W+1)'(BLOCK_COUNT - 1);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(BLOCK_COUNT - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] head_q, head_d;
    logic [ID_W-1:0] tail_q, tail_d;
    logic [ID_W:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            rdy_q, rdy_d;
    logic            err_uf_q, err_uf_d;
    logic            err_of_q, err_of_d;

    logic [ID_W-1:0] entry_q [BLOCK_COUNT];
    logic            wr_en;
    logic [ID_W-1:0] wr_idx;
    logic [ID_W-1:0] wr_data;

    logic            alloc_acc;
    logic            free_acc;
    logic            dbl_free;

    // Pointers wrap at BLOCK_COUNT-1, which need not be a power of two.
    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
        return (p == LAST_ID) ? '0 : p + 1'b1;
    endfunction

    assign alloc_valid = rdy_q & ~empty_q;
    // Storage is not reset, so hide it until initialisation has filled it.
    assign alloc_id    = rdy_q ? entry_q[head_q] : '0;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign rdy         = rdy_q;
    assign err_underflow = err_uf_q;
    assign err_overflow  = err_of_q;

    assign alloc_acc = alloc_req & alloc_valid;
    // A full list can still take a free when an allocate drains it the same cycle.
    assign free_acc  = rdy_q & free_valid & (~full_q | alloc_acc) & ~dbl_free;

`ifdef RESERVATION_FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [BLOCK_COUNT-1:0] alloc_map_q, alloc_map_d;
    logic                   err_df_q, err_df_d;
    logic                   free_hit;

    // IDs >= BLOCK_COUNT match no bit, so they read as "not allocated".
    always_comb begin
        free_hit = 1'b0;
        for (int unsigned i = 0; i < BLOCK_COUNT; i++) begin
            if (free_id == ID_W'(i)) begin
                free_hit = alloc_map_q[i];
            end
        end
    end

    // The bitmap is sampled before this cycle's allocate sets its bit, so an
    // allocate and free of the same ID in one cycle counts as a double free.
    assign dbl_free = rdy_q & free_valid & ~free_hit;

    always_comb begin
        alloc_map_d = alloc_map_q;
        if (state_q == ST_INIT) begin
            alloc_map_d = '0;
        end else begin
            for (int unsigned i = 0; i < BLOCK_COUNT; i++) begin
                if (alloc_acc && (head_q == ID_W'(i))) begin
                    alloc_map_d[i] = 1'b1;
                end
                if (free_acc && (free_id == ID_W'(i))) begin
                    alloc_map_d[i] = 1'b0;
                end
            end
        end
    end

    assign err_df_d        = dbl_free;
    assign err_double_free = err_df_q;
`else
    assign dbl_free        = 1'b0;
    assign err_double_free = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rdy_d    = rdy_q;
        err_uf_d = 1'b0;
        err_of_d = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = tail_q;
        wr_data  = free_id;

        case (state_q)
            ST_INIT: begin
                // The tail pointer doubles as the fill index; it wraps back
                // to 0 on the last write, which is exactly the READY value.
                wr_en   = 1'b1;
                wr_data = tail_q;
                tail_d  = ptr_inc(tail_q);
                count_d = count_q + 1'b1;
                if (count_q == COUNT_LAST) begin
                    state_d = ST_READY;
                    rdy_d   = 1'b1;
                end
            end
            ST_READY: begin
                if (alloc_acc) begin
                    head_d = ptr_inc(head_q);
                end
                if (free_acc) begin
                    wr_en  = 1'b1;
                    tail_d = ptr_inc(tail_q);
                end
                case ({alloc_acc, free_acc})
                    2'b10:   count_d = count_q - 1'b1;
                    2'b01:   count_d = count_q + 1'b1;
                    default: count_d = count_q;
                endcase
                err_uf_d = alloc_req & ~alloc_valid;
                err_of_d = free_valid & full_q & ~alloc_acc & ~dbl_free;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        full_d  = (count_d == COUNT_MAX);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            rdy_q    <= 1'b0;
            err_uf_q <= 1'b0;
            err_of_q <= 1'b0;
`ifdef RESERVATION_FREE_LIST_DOUBLE_FREE_CHECK_EN
            alloc_map_q <= '0;
            err_df_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            rdy_q    <= rdy_d;
            err_uf_q <= err_uf_d;
            err_of_q <= err_of_d;
`ifdef RESERVATION_FREE_LIST_DOUBLE_FREE_CHECK_EN
            alloc_map_q <= alloc_map_d;
            err_df_q    <= err_df_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_reservation_free_list.sv
// Bench for reservation_free_list: an 8-entry instance for the directed
// sequences and a 6-entry instance for pointer wrap at a non-power-of-two
// size. Expected allocate IDs are queued when a request is issued and popped
// by a monitor whenever the DUT accepts an allocate.
module tb_reservation_free_list;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned nchk = 0;
    int unsigned nerr = 0;

    // 8-entry instance
    logic       a8_req, a8_valid, f8_valid;
    logic [2:0] a8_id, f8_id;
    logic [3:0] c8;
    logic       full8, empty8, rdy8, uf8, of8, df8;

    // 6-entry instance
    logic       a6_req, a6_valid, f6_valid;
    logic [2:0] a6_id, f6_id;
    logic [3:0] c6;
    logic       full6, empty6, rdy6, uf6, of6, df6;

    reservation_free_list #(.BLOCK_COUNT(8)) u8 (
        .clk(clk), .rst(rst),
        .alloc_req(a8_req), .alloc_valid(a8_valid), .alloc_id(a8_id),
        .free_valid(f8_valid), .free_id(f8_id),
        .count(c8), .full(full8), .empty(empty8), .rdy(rdy8),
        .err_underflow(uf8), .err_overflow(of8), .err_double_free(df8)
    );

    reservation_free_list #(.BLOCK_COUNT(6)) u6 (
        .clk(clk), .rst(rst),
        .alloc_req(a6_req), .alloc_valid(a6_valid), .alloc_id(a6_id),
        .free_valid(f6_valid), .free_id(f6_id),
        .count(c6), .full(full6), .empty(empty6), .rdy(rdy6),
        .err_underflow(uf6), .err_overflow(of6), .err_double_free(df6)
    );

    int exp8[$];
    int exp6[$];
    int e8, e6;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after posedge; this samples mid-cycle.
    always @(negedge clk) begin
        if (a8_req && a8_valid) begin
            if (exp8.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL alloc8_unexpected actual=%0d required=none", a8_id);
            end else begin
                e8 = exp8.pop_front();
                chk("alloc_id8", 32'(a8_id), 32'(e8));
            end
        end
        if (a6_req && a6_valid) begin
            if (exp6.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL alloc6_unexpected actual=%0d required=none", a6_id);
            end else begin
                e6 = exp6.pop_front();
                chk("alloc_id6", 32'(a6_id), 32'(e6));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, "_rdy"},         32'(rdy8), 0);
        chk({tag, "_count"},       32'(c8), 0);
        chk({tag, "_empty"},       32'(empty8), 1);
        chk({tag, "_full"},        32'(full8), 0);
        chk({tag, "_alloc_valid"}, 32'(a8_valid), 0);
        chk({tag, "_alloc_id"},    32'(a8_id), 0);
        chk({tag, "_errs"},        32'({uf8, of8, df8}), 0);
    endtask

    task automatic init_replay8(input string tag);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk({tag, "_count"}, 32'(c8), 32'(k));
            chk({tag, "_rdy"},   32'(rdy8), (k == 8) ? 1 : 0);
        end
        chk({tag, "_full"},     32'(full8), 1);
        chk({tag, "_alloc_id"}, 32'(a8_id), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int model6[$];
    int out6[$];
    int refill[7] = '{0, 1, 2, 3, 4, 5, 7};
    int exp_cnt;
    int fid;
    bit do_a, do_f;

    initial begin
        rst = 1'b1;
        a8_req = 0; f8_valid = 0; f8_id = '0;
        a6_req = 0; f6_valid = 0; f6_id = '0;
        step();
        step();
        chk_reset8("rst");
        rst = 1'b0;

        // Initialisation; requests during INIT are ignored without errors.
        for (int k = 1; k <= 8; k++) begin
            a8_req   = (k <= 3);
            f8_valid = (k <= 3);
            f8_id    = 3'd3;
            step();
            a8_req   = 0;
            f8_valid = 0;
            chk("init_count", 32'(c8), 32'(k));
            chk("init_rdy",   32'(rdy8), (k == 8) ? 1 : 0);
            if (k <= 4) chk("init_no_err", 32'({uf8, of8, df8}), 0);
        end
        chk("ready_full",        32'(full8), 1);
        chk("ready_empty",       32'(empty8), 0);
        chk("ready_alloc_id",    32'(a8_id), 0);
        chk("ready_alloc_valid", 32'(a8_valid), 1);

        // Drain all eight IDs back-to-back.
        for (int i = 0; i < 8; i++) begin
            exp8.push_back(i);
            a8_req = 1;
            step();
        end
        a8_req = 0;
        chk("drain_count",       32'(c8), 0);
        chk("drain_empty",       32'(empty8), 1);
        chk("drain_alloc_valid", 32'(a8_valid), 0);
        chk("drain_sb8",         32'(exp8.size()), 0);

        // Ninth request underflows.
        a8_req = 1;
        step();
        a8_req = 0;
        chk("uf_pulse", 32'(uf8), 1);
        chk("uf_count", 32'(c8), 0);
        step();
        chk("uf_pulse_end", 32'(uf8), 0);

        // Free 5, then allocate with a simultaneous free of 3.
        f8_valid = 1; f8_id = 3'd5;
        step();
        f8_valid = 0;
        chk("free5_count", 32'(c8), 1);
        chk("free5_head",  32'(a8_id), 5);
        exp8.push_back(5);
        a8_req = 1; f8_valid = 1; f8_id = 3'd3;
        step();
        a8_req = 0; f8_valid = 0;
        chk("simul_count", 32'(c8), 1);
        chk("simul_head",  32'(a8_id), 3);
        chk("simul_errs",  32'({uf8, of8, df8}), 0);
        exp8.push_back(3);
        a8_req = 1;
        step();
        a8_req = 0;
        chk("empty_again", 32'(c8), 0);

        // Empty: allocate rejected, free accepted, no bypass.
        a8_req = 1; f8_valid = 1; f8_id = 3'd6;
        step();
        a8_req = 0; f8_valid = 0;
        chk("empty_simul_uf",    32'(uf8), 1);
        chk("empty_simul_count", 32'(c8), 1);
        chk("empty_simul_head",  32'(a8_id), 6);

        // Refill to full; list order is now 6,0,1,2,3,4,5,7.
        foreach (refill[i]) begin
            f8_valid = 1; f8_id = 3'(refill[i]);
            step();
        end
        f8_valid = 0;
        chk("refill_count", 32'(c8), 8);
        chk("refill_full",  32'(full8), 1);

        // Free of ID 2 while full.
        f8_valid = 1; f8_id = 3'd2;
        step();
        f8_valid = 0;
`ifdef RESERVATION_FREE_LIST_DOUBLE_FREE_CHECK_EN
        chk("full_free_df", 32'(df8), 1);
        chk("full_free_of", 32'(of8), 0);
`else
        chk("full_free_of", 32'(of8), 1);
        chk("full_free_df", 32'(df8), 0);
`endif
        chk("full_free_count", 32'(c8), 8);

        // Take 6, then free 2 (still in the list) while not full.
        exp8.push_back(6);
        a8_req = 1;
        step();
        a8_req = 0;
        chk("take6_count", 32'(c8), 7);
        f8_valid = 1; f8_id = 3'd2;
        step();
        f8_valid = 0;
`ifdef RESERVATION_FREE_LIST_DOUBLE_FREE_CHECK_EN
        chk("stale_free_df",    32'(df8), 1);
        chk("stale_free_count", 32'(c8), 7);
        exp_cnt = 7;
`else
        chk("stale_free_df",    32'(df8), 0);
        chk("stale_free_count", 32'(c8), 8);
        exp_cnt = 8;
`endif

        // Allocate down to count 3, then reset mid-stream.
        for (int i = 0; i < exp_cnt - 3; i++) begin
            exp8.push_back(refill[i]);
            a8_req = 1;
            step();
        end
        a8_req = 0;
        chk("pre_rst_count", 32'(c8), 3);
        chk("pre_rst_sb8",   32'(exp8.size()), 0);
        rst = 1'b1;
        a8_req = 1;
        #1;
        chk_reset8("midrst");
        step();
        rst = 1'b0;
        a8_req = 0;
        init_replay8("replay");
        exp8.push_back(0);
        exp8.push_back(1);
        a8_req = 1;
        step();
        step();
        a8_req = 0;
        chk("replay_alloc_count", 32'(c8), 6);

        // 6-entry instance: interleaved traffic, FIFO order through wrap.
        chk("w6_rdy",   32'(rdy6), 1);
        chk("w6_count", 32'(c6), 6);
        chk("w6_full",  32'(full6), 1);
        for (int i = 0; i < 6; i++) model6.push_back(i);
        for (int c = 0; c < 20; c++) begin
            do_a = (c % 4 != 3);
            do_f = (c % 2 == 1) && (out6.size() > 0);
            fid  = 0;
            if (do_f) fid = out6.pop_front();
            if (do_a) begin
                e6 = model6.pop_front();
                exp6.push_back(e6);
                out6.push_back(e6);
            end
            if (do_f) model6.push_back(fid);
            a6_req = do_a; f6_valid = do_f; f6_id = 3'(fid);
            step();
            chk("w6_count_step", 32'(c6), 32'(model6.size()));
        end
        a6_req = 0; f6_valid = 0;
        chk("w6_sb_drained", 32'(exp6.size()), 0);
        chk("w6_no_err",     32'({uf6, of6, df6}), 0);
`ifdef RESERVATION_FREE_LIST_DOUBLE_FREE_CHECK_EN
        f6_valid = 1; f6_id = 3'd7;
        step();
        f6_valid = 0;
        chk("w6_oor_df",    32'(df6), 1);
        chk("w6_oor_count", 32'(c6), 32'(model6.size()));
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
